datapath_regfile: RTL and testbench

- Parametrised register file for the next-generation datapath.
- Register 0 is the program counter (PC), with auto-increment.
- Generalised to REG_COUNT registers of DATA_W bits and READ_PORTS asynchronous read ports.
- Adds a split-transaction memory-load engine (request/response handshake) with busy, hazard and collision reporting, replacing the single-cycle memory load.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/regfile_load_engine.sv | 70 +++++++
 rtl/datapath_regfile.sv | 106 ++++++++++
 tb/tb_datapath_regfile.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath register file: write-source selects,
// load-engine states and the PC register index.
package datapath_pkg;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_ALU  = 2'b01,
        WR_MEM  = 2'b10,
        WR_IMM  = 2'b11
    } wr_src_e;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_REQ  = 2'b01,
        LD_WAIT = 2'b10
    } ld_state_e;

    localparam int PC_INDEX = 0;

endpackage

// File: rtl/regfile_load_engine.sv
// Split-transaction load engine: latches a load, drives the request handshake,
// waits for the response and raises a one-cycle writeback strobe.
module regfile_load_engine
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int AW     = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [AW-1:0]     start_dest,
    input  logic [DATA_W-1:0] start_addr,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [DATA_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              busy,
    output logic [AW-1:0]     dest,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data
);

    ld_state_e state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= LD_IDLE;
            dest          <= '0;
            mem_req_addr  <= '0;
            mem_req_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                LD_IDLE: begin
                    if (start) begin
                        dest          <= start_dest;
                        mem_req_addr  <= start_addr;
                        mem_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= LD_REQ;
                    end
                end
                LD_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (mem_rsp_valid) begin
                        busy  <= 1'b0;
                        state <= LD_IDLE;
                    end
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= LD_IDLE;
                end
            endcase
        end
    end

    // Responses outside WAIT (including stray ones after a reset) are ignored.
    assign wb_valid = (state == LD_WAIT) && mem_rsp_valid;
    assign wb_data  = mem_rsp_data;

endmodule

// File: rtl/datapath_regfile.sv
// Parametrised register file with auto-incrementing PC in register 0,
// asynchronous read ports and a split-transaction memory-load path.
module datapath_regfile
    import datapath_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int REG_COUNT  = 16,
    parameter  int READ_PORTS = 2,
    localparam int AW         = $clog2(REG_COUNT)
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         pc_increment,
    input  logic [1:0]                   wr_src,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DATA_W-1:0]            alu_result,
    input  logic [DATA_W-1:0]            immediate,
    input  logic [DATA_W-1:0]            load_addr,
    input  logic [READ_PORTS*AW-1:0]     rd_addr,
    output logic [READ_PORTS*DATA_W-1:0] rd_data,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [DATA_W-1:0]            mem_req_addr,
    input  logic                         mem_rsp_valid,
    input  logic [DATA_W-1:0]            mem_rsp_data,
    output logic                         busy,
    output logic [READ_PORTS-1:0]        hazard,
    output logic                         collision,
    output logic [DATA_W-1:0]            pc,
    output logic [REG_COUNT*DATA_W-1:0]  registers
);

    logic [DATA_W-1:0] regs [REG_COUNT];
    logic              ld_start;
    logic [AW-1:0]     ld_dest;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic              dir_wr;
    logic [DATA_W-1:0] dir_data;
    logic [DATA_W-1:0] pc_base;
    logic              collision_set;

    function automatic logic [DATA_W-1:0] pc_next(input logic [DATA_W-1:0] base,
                                                  input logic              inc);
        return base + {{(DATA_W-1){1'b0}}, inc};
    endfunction

    assign ld_start = (wr_src == WR_MEM);

    regfile_load_engine #(.DATA_W(DATA_W), .AW(AW)) u_load (
        .clock         (clock),
        .resetn        (resetn),
        .start         (ld_start),
        .start_dest    (wr_addr),
        .start_addr    (load_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy),
        .dest          (ld_dest),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data)
    );

    always_comb begin
        dir_wr   = (wr_src == WR_ALU) || (wr_src == WR_IMM);
        dir_data = (wr_src == WR_IMM) ? immediate : alu_result;
        pc_base  = regs[PC_INDEX];
        // Memory writeback has priority over a same-edge direct write.
        if (wb_valid && ld_dest == AW'(PC_INDEX))
            pc_base = wb_data;
        else if (dir_wr && wr_addr == AW'(PC_INDEX))
            pc_base = dir_data;
        collision_set = (wb_valid && dir_wr && wr_addr == ld_dest) || (ld_start && busy);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            collision <= 1'b0;
        end else begin
            regs[PC_INDEX] <= pc_next(pc_base, pc_increment);
            for (int i = 1; i < REG_COUNT; i++) begin
                if (wb_valid && ld_dest == AW'(i))
                    regs[i] <= wb_data;
                else if (dir_wr && wr_addr == AW'(i))
                    regs[i] <= dir_data;
            end
            if (collision_set) collision <= 1'b1;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        assign rd_data[p*DATA_W +: DATA_W] = regs[rd_addr[p*AW +: AW]];
        assign hazard[p] = busy && (rd_addr[p*AW +: AW] == ld_dest);
    end

    for (genvar r = 0; r < REG_COUNT; r++) begin : g_flat
        assign registers[r*DATA_W +: DATA_W] = regs[r];
    end

    assign pc = regs[PC_INDEX];

endmodule

// File: tb/tb_datapath_regfile.sv
// Bench for datapath_regfile: directed scenarios plus randomized traffic checked
// against a transaction-level model; a wide instance covers packed-port indexing.
module tb_datapath_regfile;

    logic         clk = 1'b0;
    logic         resetn;
    logic         pc_increment;
    logic [1:0]   wr_src;
    logic [3:0]   wr_addr;
    logic [15:0]  alu_result, immediate, load_addr;
    logic [7:0]   rd_addr;
    logic [31:0]  rd_data;
    logic         mem_req_valid, mem_req_ready;
    logic [15:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [15:0]  mem_rsp_data;
    logic         busy;
    logic [1:0]   hazard;
    logic         collision;
    logic [15:0]  pc;
    logic [255:0] registers;

    logic          w_resetn;
    logic          w_pc_increment;
    logic [1:0]    w_wr_src;
    logic [4:0]    w_wr_addr;
    logic [31:0]   w_alu_result, w_immediate, w_load_addr;
    logic [14:0]   w_rd_addr;
    logic [95:0]   w_rd_data;
    logic          w_mem_req_valid, w_mem_req_ready;
    logic [31:0]   w_mem_req_addr;
    logic          w_mem_rsp_valid;
    logic [31:0]   w_mem_rsp_data;
    logic          w_busy;
    logic [2:0]    w_hazard;
    logic          w_collision;
    logic [31:0]   w_pc;
    logic [1023:0] w_registers;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural registers plus one outstanding load record.
    logic [15:0] m_regs [16];
    bit          m_pending, m_accepted, m_coll;
    logic [3:0]  m_dest;
    logic [15:0] m_addr;

    always #5 clk = ~clk;

    datapath_regfile dut (
        .clock(clk), .resetn(resetn), .pc_increment(pc_increment), .wr_src(wr_src),
        .wr_addr(wr_addr), .alu_result(alu_result), .immediate(immediate),
        .load_addr(load_addr), .rd_addr(rd_addr), .rd_data(rd_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .busy(busy), .hazard(hazard),
        .collision(collision), .pc(pc), .registers(registers)
    );

    datapath_regfile #(.DATA_W(32), .REG_COUNT(32), .READ_PORTS(3)) dut_w (
        .clock(clk), .resetn(w_resetn), .pc_increment(w_pc_increment), .wr_src(w_wr_src),
        .wr_addr(w_wr_addr), .alu_result(w_alu_result), .immediate(w_immediate),
        .load_addr(w_load_addr), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
        .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready),
        .mem_req_addr(w_mem_req_addr), .mem_rsp_valid(w_mem_rsp_valid),
        .mem_rsp_data(w_mem_rsp_data), .busy(w_busy), .hazard(w_hazard),
        .collision(w_collision), .pc(w_pc), .registers(w_registers)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_regs[r] = '0;
        m_pending = 0; m_accepted = 0; m_coll = 0; m_dest = '0; m_addr = '0;
    endtask

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_step();
        logic [15:0] nxt [16];
        bit          dir, wb;
        for (int r = 0; r < 16; r++) nxt[r] = m_regs[r];
        dir = (wr_src == 2'b01) || (wr_src == 2'b11);
        wb  = m_pending && m_accepted && mem_rsp_valid;
        if (dir) nxt[wr_addr] = (wr_src == 2'b11) ? immediate : alu_result;
        if (wb) begin
            if (dir && wr_addr == m_dest) m_coll = 1;
            nxt[m_dest] = mem_rsp_data;
        end
        if (wr_src == 2'b10 && m_pending) m_coll = 1;
        nxt[0] = nxt[0] + 16'(pc_increment);
        if (!m_pending) begin
            if (wr_src == 2'b10) begin
                m_pending = 1; m_accepted = 0; m_dest = wr_addr; m_addr = load_addr;
            end
        end else if (!m_accepted) begin
            if (mem_req_ready) m_accepted = 1;
        end else if (mem_rsp_valid) begin
            m_pending = 0;
        end
        for (int r = 0; r < 16; r++) m_regs[r] = nxt[r];
    endtask

    task automatic compare_all();
        for (int r = 0; r < 16; r++)
            chk($sformatf("reg%0d", r), 64'(registers[r*16 +: 16]), 64'(m_regs[r]));
        chk("pc", 64'(pc), 64'(m_regs[0]));
        chk("busy", 64'(busy), 64'(m_pending));
        chk("req_valid", 64'(mem_req_valid), 64'(m_pending && !m_accepted));
        if (m_pending && !m_accepted) chk("req_addr", 64'(mem_req_addr), 64'(m_addr));
        chk("collision", 64'(collision), 64'(m_coll));
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rd_data%0d", p), 64'(rd_data[p*16 +: 16]), 64'(m_regs[rd_addr[p*4 +: 4]]));
            chk($sformatf("hazard%0d", p), 64'(hazard[p]), 64'(m_pending && rd_addr[p*4 +: 4] == m_dest));
        end
    endtask

    task automatic idle_inputs();
        pc_increment = 0; wr_src = 2'b00; wr_addr = '0; alu_result = '0; immediate = '0;
        load_addr = '0; rd_addr = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic tick();
        #1 compare_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        #1 compare_all();
        resetn = 1;
    endtask

    task automatic w_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        resetn = 0;
        w_resetn = 0; w_pc_increment = 0; w_wr_src = '0; w_wr_addr = '0; w_alu_result = '0;
        w_immediate = '0; w_load_addr = '0; w_rd_addr = '0; w_mem_req_ready = 0;
        w_mem_rsp_valid = 0; w_mem_rsp_data = '0;
        @(negedge clk);

        // Reset then a first ALU write with PC increment
        do_reset();
        chk("rst_pc", 64'(pc), 64'h0);
        chk("rst_regs", 64'(registers == '0), 64'h1);
        pc_increment = 1; wr_src = 2'b01; wr_addr = 7; alu_result = 16'h0002;
        tick();
        chk("alu_reg7", 64'(registers[7*16 +: 16]), 64'h0002);
        chk("alu_pc", 64'(pc), 64'h0001);

        // Jumps and PC wrap
        wr_addr = 0; alu_result = 16'h0002; pc_increment = 1;
        tick();
        chk("jump_inc", 64'(pc), 64'h0003);
        pc_increment = 0;
        tick();
        chk("jump_noinc", 64'(pc), 64'h0002);
        wr_src = 2'b11; immediate = 16'hFFFF;
        tick();
        wr_src = 2'b00; pc_increment = 1;
        tick();
        chk("pc_wrap", 64'(pc), 64'h0000);

        // Load with request backpressure
        do_reset();
        wr_src = 2'b10; wr_addr = 6; load_addr = 16'h0002; rd_addr = 8'h06;
        tick();
        wr_src = 2'b00;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bp_req_valid", 64'(mem_req_valid), 64'h1);
            chk("bp_req_addr", 64'(mem_req_addr), 64'h0002);
            chk("bp_hazard0", 64'(hazard[0]), 64'h1);
            tick();
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        chk("bp_busy_wait", 64'(busy), 64'h1);
        tick();
        mem_rsp_valid = 1; mem_rsp_data = 16'h00AB;
        tick();
        mem_rsp_valid = 0;
        chk("bp_reg6", 64'(registers[6*16 +: 16]), 64'h00AB);
        chk("bp_busy_low", 64'(busy), 64'h0);

        // Same-edge direct write vs. memory writeback
        do_reset();
        wr_src = 2'b10; wr_addr = 3; load_addr = 16'h0010;
        tick();
        wr_src = 2'b00; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        wr_src = 2'b11; wr_addr = 3; immediate = 16'h1234;
        mem_rsp_valid = 1; mem_rsp_data = 16'h5555;
        tick();
        idle_inputs();
        chk("coll_reg3", 64'(registers[3*16 +: 16]), 64'h5555);
        chk("coll_flag", 64'(collision), 64'h1);

        // Second load while busy is dropped
        do_reset();
        wr_src = 2'b10; wr_addr = 4; load_addr = 16'h0010;
        tick();
        wr_addr = 9; load_addr = 16'h0077;
        tick();
        wr_src = 2'b00;
        chk("drop_coll", 64'(collision), 64'h1);
        chk("drop_addr", 64'(mem_req_addr), 64'h0010);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 16'h4444;
        tick();
        mem_rsp_valid = 0;
        tick();
        chk("drop_no_req", 64'(mem_req_valid), 64'h0);
        chk("drop_reg4", 64'(registers[4*16 +: 16]), 64'h4444);
        chk("drop_reg9", 64'(registers[9*16 +: 16]), 64'h0);

        // Load into the PC
        do_reset();
        wr_src = 2'b10; wr_addr = 0; load_addr = 16'h0020;
        tick();
        wr_src = 2'b00; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 16'h0040; pc_increment = 1;
        tick();
        idle_inputs();
        chk("ldpc_pc", 64'(pc), 64'h0041);

        // Asynchronous reset during REQ
        do_reset();
        wr_src = 2'b10; wr_addr = 5; load_addr = 16'h0030;
        tick();
        wr_src = 2'b00;
        #1 chk("rreq_pre_valid", 64'(mem_req_valid), 64'h1);
        #1 resetn = 0;
        #1 chk("rreq_valid", 64'(mem_req_valid), 64'h0);
        chk("rreq_busy", 64'(busy), 64'h0);
        @(negedge clk);
        resetn = 1;
        model_reset();

        // Asynchronous reset during WAIT, then a stray response
        wr_src = 2'b10; wr_addr = 5; load_addr = 16'h0030;
        tick();
        wr_src = 2'b00; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        #1 chk("rwait_pre_busy", 64'(busy), 64'h1);
        #1 resetn = 0;
        #1 chk("rwait_busy", 64'(busy), 64'h0);
        chk("rwait_valid", 64'(mem_req_valid), 64'h0);
        @(negedge clk);
        resetn = 1;
        model_reset();
        mem_rsp_valid = 1; mem_rsp_data = 16'hBEEF;
        tick();
        mem_rsp_valid = 0;
        chk("stray_regs", 64'(registers == '0), 64'h1);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            wr_src       = 2'($urandom_range(3, 0));
            wr_addr      = 4'($urandom_range(15, 0));
            if (m_pending && $urandom_range(3, 0) == 0) wr_addr = m_dest;
            alu_result   = 16'($urandom);
            immediate    = 16'($urandom);
            load_addr    = 16'($urandom);
            pc_increment = 1'($urandom_range(1, 0));
            rd_addr[3:0] = ($urandom_range(1, 0) == 0) ? m_dest : 4'($urandom_range(15, 0));
            rd_addr[7:4] = 4'($urandom_range(15, 0));
            mem_req_ready = 1'($urandom_range(1, 0));
            mem_rsp_valid = ($urandom_range(2, 0) == 0);
            mem_rsp_data  = 16'($urandom);
            tick();
        end
        idle_inputs();

        // Wide instance: first write and packed read port 2
        w_tick();
        chk("w_rst_pc", 64'(w_pc), 64'h0);
        chk("w_rst_reg7", 64'(w_registers[7*32 +: 32]), 64'h0);
        w_resetn = 1;
        w_pc_increment = 1; w_wr_src = 2'b01; w_wr_addr = 7; w_alu_result = 32'h0000_0002;
        w_rd_addr = {5'd7, 5'd3, 5'd0};
        w_tick();
        w_pc_increment = 0; w_wr_src = 2'b00;
        chk("w_reg7", 64'(w_registers[7*32 +: 32]), 64'h2);
        chk("w_pc", 64'(w_pc), 64'h1);
        chk("w_rd2", 64'(w_rd_data[2*32 +: 32]), 64'h2);
        chk("w_rd0", 64'(w_rd_data[0 +: 32]), 64'h1);
        chk("w_rd1", 64'(w_rd_data[1*32 +: 32]), 64'h0);

        // Wide instance: load with backpressure, hazard on port 1
        w_wr_src = 2'b10; w_wr_addr = 6; w_load_addr = 32'h0000_0002;
        w_rd_addr = {5'd0, 5'd6, 5'd1};
        w_tick();
        w_wr_src = 2'b00;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("w_req_valid", 64'(w_mem_req_valid), 64'h1);
            chk("w_req_addr", 64'(w_mem_req_addr), 64'h2);
            chk("w_hazard", 64'(w_hazard), 64'h2);
            w_tick();
        end
        w_mem_req_ready = 1;
        w_tick();
        w_mem_req_ready = 0;
        chk("w_busy_wait", 64'(w_busy), 64'h1);
        w_tick();
        w_mem_rsp_valid = 1; w_mem_rsp_data = 32'h0000_00AB;
        w_tick();
        w_mem_rsp_valid = 0;
        chk("w_reg6", 64'(w_registers[6*32 +: 32]), 64'hAB);
        chk("w_rd1_load", 64'(w_rd_data[1*32 +: 32]), 64'hAB);
        chk("w_busy_low", 64'(w_busy), 64'h0);
        chk("w_hazard_clr", 64'(w_hazard), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
